// File: rtl/core_msg_rx.sv
// Per-core receive front end: decodes the scheduler message stream into a
// core-select latch, an assembled R0 register and an instruction FIFO.
module core_msg_rx #(
  parameter int CORE_ID      = 0,
  parameter int MSG_WIDTH    = 16,
  parameter int R0_DEPTH     = 8,
  parameter int R0_DATA_SIZE = 128,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [MSG_WIDTH-1:0]    mess_to_core,
  input  logic                    core_mask_loading,
  input  logic                    r0_mask_loading,
  input  logic                    r0_loading,
  input  logic                    instr_loading,
  input  logic                    core_busy,
  output logic [MSG_WIDTH-1:0]    instr_out,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [R0_DATA_SIZE-1:0] r0_data,
  output logic                    r0_valid,
  output logic                    core_reading,
  output logic                    core_ready,
  output logic                    overflow_err
);

  localparam int R0C_W = (R0_DEPTH > 1) ? $clog2(R0_DEPTH) : 1;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = AW + 1;
  localparam logic [R0C_W-1:0] R0_LAST = R0C_W'(R0_DEPTH - 1);
  localparam logic [CW-1:0]    FULL_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MASKED  = 2'd1,
    ST_R0_LOAD = 2'd2
  } state_t;

  state_t                  state_r, state_next_s;
  logic                    selected_r, r0_sel_r;
  logic [R0C_W-1:0]        r0_cnt_r;
  logic [R0_DATA_SIZE-1:0] shadow_r, r0_data_r, assembled_s;
  logic                    r0_valid_r, overflow_r;
  logic [MSG_WIDTH-1:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]           count_r;
  logic                    cm_s, rm_s, rw_s, iw_s, own_bit_s;
  logic                    r0_word_s, r0_last_s;
  logic                    full_s, push_req_s, push_s, pop_s;
  logic                    core_ready_s, core_reading_s;

  assign own_bit_s = mess_to_core[CORE_ID];

  // Strobe priority decode: core_mask > r0_mask > r0 > instr.
  always_comb begin
    cm_s       = core_mask_loading;
    rm_s       = r0_mask_loading & ~core_mask_loading;
    rw_s       = r0_loading & ~core_mask_loading & ~r0_mask_loading;
    iw_s       = instr_loading & ~core_mask_loading & ~r0_mask_loading & ~r0_loading;
    r0_word_s  = rw_s & r0_sel_r;
    r0_last_s  = r0_word_s & (r0_cnt_r == R0_LAST);
    full_s     = (count_r == FULL_C);
    pop_s      = (count_r != {CW{1'b0}}) & instr_ready;
    push_req_s = iw_s & selected_r;
    push_s     = push_req_s & (~full_s | pop_s);
  end

  // Shadow buffer with the current word merged in, used for both shadow and final copy.
  always_comb begin
    assembled_s = shadow_r;
    assembled_s[int'(r0_cnt_r)*MSG_WIDTH +: MSG_WIDTH] = mess_to_core;
  end

  // Select latch, R0 arm flag and R0 word counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      selected_r <= 1'b0;
      r0_sel_r   <= 1'b0;
      r0_cnt_r   <= {R0C_W{1'b0}};
    end else if (cm_s) begin
      selected_r <= own_bit_s;
      r0_sel_r   <= 1'b0;
      r0_cnt_r   <= {R0C_W{1'b0}};
    end else if (rm_s) begin
      r0_sel_r   <= own_bit_s & selected_r;
    end else if (r0_word_s) begin
      if (r0_last_s) begin
        r0_sel_r <= 1'b0;
        r0_cnt_r <= {R0C_W{1'b0}};
      end else begin
        r0_cnt_r <= r0_cnt_r + R0C_W'(1);
      end
    end
  end

  // R0 shadow assembly and publication on the final word.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_r   <= {R0_DATA_SIZE{1'b0}};
      r0_data_r  <= {R0_DATA_SIZE{1'b0}};
      r0_valid_r <= 1'b0;
    end else begin
      r0_valid_r <= r0_last_s;
      if (r0_word_s) shadow_r  <= assembled_s;
      if (r0_last_s) r0_data_r <= assembled_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_next_s;
  end

  // FSM next state; a core mask message overrides every state.
  always_comb begin
    state_next_s = state_r;
    if (cm_s) begin
      state_next_s = own_bit_s ? ST_MASKED : ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:    state_next_s = ST_IDLE;
        ST_MASKED:  state_next_s = (rm_s & own_bit_s) ? ST_R0_LOAD : ST_MASKED;
        ST_R0_LOAD: state_next_s = r0_last_s ? ST_MASKED : ST_R0_LOAD;
        default:    state_next_s = ST_IDLE;
      endcase
    end
  end

  // FSM outputs; the reading margin of 2 absorbs the scheduler's strobe latency.
  always_comb begin
    core_ready_s   = (count_r == {CW{1'b0}}) & (state_r != ST_R0_LOAD) & ~core_busy;
    core_reading_s = ((FULL_C - count_r) >= CW'(2));
  end

  // Instruction FIFO storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= {MSG_WIDTH{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= mess_to_core;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (push_req_s & full_s & ~pop_s) overflow_r <= 1'b1;
    end
  end

  // First-word fall-through head, forced to zero when empty.
  always_comb begin
    if (count_r == {CW{1'b0}}) instr_out = {MSG_WIDTH{1'b0}};
    else                       instr_out = mem_r[rd_ptr_r];
  end

  assign instr_valid  = (count_r != {CW{1'b0}});
  assign r0_data      = r0_data_r;
  assign r0_valid     = r0_valid_r;
  assign overflow_err = overflow_r;
  assign core_ready   = core_ready_s;
  assign core_reading = core_reading_s;

endmodule
